// File: rtl/pwm_gen_pkg.sv
// rtl/pwm_gen_pkg.sv - shared state encoding and constants for the PWM generator
package pwm_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } pwm_state_e;

  localparam int PWM_MIN_PERIOD = 2;

endpackage

// File: rtl/pwm_cfg_shadow.sv
// rtl/pwm_cfg_shadow.sv - pending/active configuration registers with period clamp
// and cfg_ready generation; updates land immediately in IDLE or at a period boundary.
module pwm_cfg_shadow #(
  parameter int CNT_W      = 16,
  parameter int DEF_PERIOD = 100,
  parameter int DEF_HIGH   = 50
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             cfg_valid_i,
  input  logic [CNT_W-1:0] cfg_period_i,
  input  logic [CNT_W-1:0] cfg_high_i,
  input  logic             load_now_i,
  input  logic             boundary_i,
  output logic             cfg_ready_o,
  output logic [CNT_W-1:0] act_period_o,
  output logic [CNT_W-1:0] act_high_next_o
);
  import pwm_gen_pkg::*;

  localparam logic [CNT_W-1:0] MIN_P = CNT_W'(PWM_MIN_PERIOD);
  localparam logic [CNT_W-1:0] DEF_P = CNT_W'(DEF_PERIOD);
  localparam logic [CNT_W-1:0] DEF_H = CNT_W'(DEF_HIGH);

  logic             ready_q, ready_d;
  logic             pend_valid_q, pend_valid_d;
  logic [CNT_W-1:0] pend_period_q, pend_period_d;
  logic [CNT_W-1:0] pend_high_q, pend_high_d;
  logic [CNT_W-1:0] act_period_q, act_period_d;
  logic [CNT_W-1:0] act_high_q, act_high_d;
  logic [CNT_W-1:0] clamped_period;
  logic             accept;
  logic             apply_now;

  assign accept         = cfg_valid_i && ready_q;
  assign apply_now      = load_now_i || boundary_i;
  assign clamped_period = (cfg_period_i < MIN_P) ? MIN_P : cfg_period_i;

  always_comb begin
    ready_d       = ready_q;
    pend_valid_d  = pend_valid_q;
    pend_period_d = pend_period_q;
    pend_high_d   = pend_high_q;
    act_period_d  = act_period_q;
    act_high_d    = act_high_q;
    if (accept) begin
      // A transfer always closes the handshake for at least one cycle.
      ready_d = 1'b0;
      if (apply_now) begin
        act_period_d = clamped_period;
        act_high_d   = cfg_high_i;
      end else begin
        pend_valid_d  = 1'b1;
        pend_period_d = clamped_period;
        pend_high_d   = cfg_high_i;
      end
    end else if (pend_valid_q) begin
      if (apply_now) begin
        act_period_d = pend_period_q;
        act_high_d   = pend_high_q;
        pend_valid_d = 1'b0;
        ready_d      = 1'b1;
      end
    end else begin
      ready_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ready_q       <= 1'b1;
      pend_valid_q  <= 1'b0;
      pend_period_q <= DEF_P;
      pend_high_q   <= DEF_H;
      act_period_q  <= DEF_P;
      act_high_q    <= DEF_H;
    end else begin
      ready_q       <= ready_d;
      pend_valid_q  <= pend_valid_d;
      pend_period_q <= pend_period_d;
      pend_high_q   <= pend_high_d;
      act_period_q  <= act_period_d;
      act_high_q    <= act_high_d;
    end
  end

  assign cfg_ready_o     = ready_q;
  assign act_period_o    = act_period_q;
  assign act_high_next_o = act_high_d;

endmodule

// File: rtl/pwm_signal_gen.sv
// rtl/pwm_signal_gen.sv - programmable PWM generator: run/drain FSM, phase counter,
// registered waveform, period strobe and completed-period counter.
module pwm_signal_gen #(
  parameter int CNT_W      = 16,
  parameter int DEF_PERIOD = 100,
  parameter int DEF_HIGH   = 50
) (
  input  logic             sys_clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CNT_W-1:0] cfg_period,
  input  logic [CNT_W-1:0] cfg_high,
  output logic             pwm_out,
  output logic             period_start,
  output logic             running,
  output logic [CNT_W-1:0] period_cnt
);
  import pwm_gen_pkg::*;

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  pwm_state_e       state_q, state_d;
  logic [CNT_W-1:0] k_q, k_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pwm_q, pwm_d;
  logic             start_q, start_d;
  logic             run_q, run_d;
  logic [CNT_W-1:0] act_period;
  logic [CNT_W-1:0] act_high_nx;
  logic             wrap;
  logic             load_now;

  assign load_now = (state_q == ST_IDLE);
  assign wrap     = (state_q != ST_IDLE) && (k_q >= act_period - ONE);

  pwm_cfg_shadow #(
    .CNT_W      (CNT_W),
    .DEF_PERIOD (DEF_PERIOD),
    .DEF_HIGH   (DEF_HIGH)
  ) u_cfg_shadow (
    .clk_i           (sys_clk),
    .rst_i           (rst),
    .cfg_valid_i     (cfg_valid),
    .cfg_period_i    (cfg_period),
    .cfg_high_i      (cfg_high),
    .load_now_i      (load_now),
    .boundary_i      (wrap),
    .cfg_ready_o     (cfg_ready),
    .act_period_o    (act_period),
    .act_high_next_o (act_high_nx)
  );

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (enable) begin
          state_d = ST_RUN;
          k_d     = '0;
          cnt_d   = '0;
        end
      end
      ST_RUN, ST_DRAIN: begin
        if (wrap) begin
          // Enable low at the last cycle means the period just completed: stop here.
          k_d     = '0;
          cnt_d   = cnt_q + ONE;
          state_d = enable ? ST_RUN : ST_IDLE;
        end else begin
          k_d     = k_q + ONE;
          state_d = enable ? ST_RUN : ST_DRAIN;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    run_d   = (state_d != ST_IDLE);
    pwm_d   = run_d && (k_d < act_high_nx);
    start_d = run_d && (k_d == '0);
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      k_q     <= '0;
      cnt_q   <= '0;
      pwm_q   <= 1'b0;
      start_q <= 1'b0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      cnt_q   <= cnt_d;
      pwm_q   <= pwm_d;
      start_q <= start_d;
      run_q   <= run_d;
    end
  end

  assign pwm_out      = pwm_q;
  assign period_start = start_q;
  assign running      = run_q;
  assign period_cnt   = cnt_q;

endmodule
